// File: rtl/exa_crosb_pkg.sv
// Shared crossbar-input definitions: default topology constants, the flit
// record layout and a small width helper used by the VC buffer.
package exa_crosb_pkg;

  localparam int PRIO_NUM    = 2;
  localparam int VC_NUM      = 2;
  localparam int OUTPUT_NUM  = 4;
  localparam int FLIT_DATA_W = 64;

  // Width of an index into n items; never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flit record for the default topology; field order {data, last, dest, output_vc}.
  typedef struct packed {
    logic [FLIT_DATA_W-1:0]                        data;
    logic                                          last;
    logic [clog2_min1(OUTPUT_NUM)-1:0]             dest;
    logic [clog2_min1(PRIO_NUM*VC_NUM)-1:0]        output_vc;
  } flit_t;

endpackage

// File: rtl/exa_crosb_vc_fifo.sv
// Single-clock per-channel flit FIFO. Head is read combinationally from the
// storage array, so a write becomes visible one cycle later (no bypass).
// Writes to a full FIFO and reads from an empty one are ignored here.
module exa_crosb_vc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rptr];

  // Storage array; contents are don't-care until the occupancy covers them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks net change.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exa_crosb_input_vc_buffer.sv
// Crossbar input VC buffer: one FIFO per (priority, VC) channel, head-field
// fan-out to the arbiter, selected-channel payload mux, registered credit
// return and a sticky overflow flag.
// Optional feature: define EXA_VCBUF_STORE_FWD_EN to request only once a
// complete packet (last flit) is buffered; default is cut-through.
module exa_crosb_input_vc_buffer
  import exa_crosb_pkg::*;
#(
  parameter int PRIO_NUM   = exa_crosb_pkg::PRIO_NUM,
  parameter int VC_NUM     = exa_crosb_pkg::VC_NUM,
  parameter int OUTPUT_NUM = exa_crosb_pkg::OUTPUT_NUM,
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 64,
  localparam int NCH       = PRIO_NUM * VC_NUM,
  localparam int CH_W      = exa_crosb_pkg::clog2_min1(NCH),
  localparam int DEST_W    = exa_crosb_pkg::clog2_min1(OUTPUT_NUM)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_valid,
  input  logic [CH_W-1:0]              i_ch,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_last,
  input  logic [DEST_W-1:0]            i_dest,
  input  logic [CH_W-1:0]              i_output_vc,
  input  logic                         i_cts,
  input  logic [CH_W-1:0]              i_sel_ch,
  output logic [NCH-1:0]               o_has_packet,
  output logic [NCH-1:0][DEST_W-1:0]   o_dest,
  output logic [NCH-1:0][CH_W-1:0]     o_output_vc,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_last,
  output logic                         o_credit_valid,
  output logic [CH_W-1:0]              o_credit_ch,
  output logic                         o_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [DEST_W-1:0] dest;
    logic [CH_W-1:0]   output_vc;
  } vc_flit_t;

  vc_flit_t       wr_flit;
  vc_flit_t       head [NCH];
  logic [NCH-1:0] full, empty, wr_req, deq;
  logic [AW:0]    occ [NCH];
  vc_flit_t       sel_flit;
  logic           sel_vld;
  logic           ovf_hit;

  assign wr_flit = '{data: i_data, last: i_last, dest: i_dest, output_vc: i_output_vc};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // The write check uses pre-dequeue occupancy: a full FIFO drops the
    // write even if its head leaves in the same cycle.
    assign wr_req[c] = i_valid && (i_ch == CH_W'(c));
    assign deq[c]    = i_cts && (i_sel_ch == CH_W'(c)) && !empty[c];

    exa_crosb_vc_fifo #(.DEPTH(DEPTH), .W($bits(vc_flit_t))) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_req[c]),
      .wr_data (wr_flit),
      .rd_en   (deq[c]),
      .rd_data (head[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .count   (occ[c])
    );

    assign o_dest[c]      = empty[c] ? '0 : head[c].dest;
    assign o_output_vc[c] = empty[c] ? '0 : head[c].output_vc;

`ifdef EXA_VCBUF_STORE_FWD_EN
    logic [AW:0] pkt_cnt;
    logic        pkt_inc, pkt_dec;

    assign pkt_inc = wr_req[c] && !full[c] && i_last;
    assign pkt_dec = deq[c] && head[c].last;

    // Count whole packets buffered; a simultaneous in/out leaves it as is.
    always_ff @(posedge clk) begin
      if (!resetn)                  pkt_cnt <= '0;
      else if (pkt_inc && !pkt_dec) pkt_cnt <= pkt_cnt + (AW+1)'(1);
      else if (pkt_dec && !pkt_inc) pkt_cnt <= pkt_cnt - (AW+1)'(1);
    end

    assign o_has_packet[c] = (pkt_cnt != '0);
`else
    assign o_has_packet[c] = !empty[c];
`endif
  end

  // Head of the arbiter-selected channel, with its occupancy qualifier.
  always_comb begin
    sel_flit = '0;
    sel_vld  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (i_sel_ch == CH_W'(c)) begin
        sel_flit = head[c];
        sel_vld  = !empty[c];
      end
    end
  end

  assign o_data = sel_vld ? sel_flit.data : '0;
  assign o_last = sel_vld && sel_flit.last;

  // Any inbound flit aimed at a full channel is an overflow.
  always_comb begin
    ovf_hit = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_req[c] && (occ[c] == (AW+1)'(DEPTH))) ovf_hit = 1'b1;
    end
  end

  // One credit per dequeued flit, one cycle after the dequeue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_credit_valid <= 1'b0;
      o_credit_ch    <= '0;
    end else begin
      o_credit_valid <= |deq;
      o_credit_ch    <= (|deq) ? i_sel_ch : '0;
    end
  end

  // Overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (!resetn)      o_overflow <= 1'b0;
    else if (ovf_hit) o_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_exa_crosb_input_vc_buffer.sv
// Bench for exa_crosb_input_vc_buffer (default parameters). A queue-per-channel
// reference model is checked every cycle; a vector table and hand sequences
// add fixed expectations for the documented scenarios.
module tb_exa_crosb_input_vc_buffer;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 i_valid;
  logic [1:0]           i_ch;
  logic [63:0]          i_data;
  logic                 i_last;
  logic [1:0]           i_dest;
  logic [1:0]           i_output_vc;
  logic                 i_cts;
  logic [1:0]           i_sel_ch;
  logic [3:0]           o_has_packet;
  logic [3:0][1:0]      o_dest;
  logic [3:0][1:0]      o_output_vc;
  logic [63:0]          o_data;
  logic                 o_last;
  logic                 o_credit_valid;
  logic [1:0]           o_credit_ch;
  logic                 o_overflow;

  always #5 clk = ~clk;

  exa_crosb_input_vc_buffer dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_ch(i_ch), .i_data(i_data),
    .i_last(i_last), .i_dest(i_dest), .i_output_vc(i_output_vc), .i_cts(i_cts),
    .i_sel_ch(i_sel_ch), .o_has_packet(o_has_packet), .o_dest(o_dest),
    .o_output_vc(o_output_vc), .o_data(o_data), .o_last(o_last),
    .o_credit_valid(o_credit_valid), .o_credit_ch(o_credit_ch), .o_overflow(o_overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [1:0]  dst;
    logic [1:0]  ovc;
  } fl_t;

  fl_t        q [NCH][$];
  logic       m_ovf;
  logic       m_cv;
  logic [1:0] m_cc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // A channel requests when it holds any flit (cut-through) or a whole packet.
  function automatic logic m_has(input int c);
`ifdef EXA_VCBUF_STORE_FWD_EN
    foreach (q[c][k]) if (q[c][k].l) return 1'b1;
    return 1'b0;
`else
    return q[c].size() != 0;
`endif
  endfunction

  task automatic check_comb(input string tag);
    logic [3:0]      e_has;
    logic [3:0][1:0] e_dst, e_ovc;
    int s;
    for (int c = 0; c < NCH; c++) begin
      e_has[c] = m_has(c);
      e_dst[c] = q[c].size() ? q[c][0].dst : 2'd0;
      e_ovc[c] = q[c].size() ? q[c][0].ovc : 2'd0;
    end
    s = int'(i_sel_ch);
    chk({tag, " has_packet"}, 64'(o_has_packet), 64'(e_has));
    chk({tag, " dest"},       64'(o_dest),       64'(e_dst));
    chk({tag, " output_vc"},  64'(o_output_vc),  64'(e_ovc));
    chk({tag, " data"},       o_data, q[s].size() ? q[s][0].d : 64'd0);
    chk({tag, " last"},       64'(o_last), 64'(q[s].size() ? q[s][0].l : 1'b0));
  endtask

  // One clock: check outputs against the model, step model and DUT together.
  task automatic cycle();
    int  ps, pc;
    bit  deq;
    #1;
    if (resetn) check_comb("pre");
    if (!resetn) begin
      for (int c = 0; c < NCH; c++) q[c].delete();
      m_ovf = 1'b0;
      m_cv  = 1'b0;
      m_cc  = 2'd0;
    end else begin
      ps  = q[i_sel_ch].size();
      pc  = q[i_ch].size();
      deq = i_cts && (ps > 0);
      if (deq) void'(q[i_sel_ch].pop_front());
      m_cv = deq;
      m_cc = i_sel_ch;
      if (i_valid) begin
        if (pc >= DEPTH) m_ovf = 1'b1;
        else q[i_ch].push_back('{d: i_data, l: i_last, dst: i_dest, ovc: i_output_vc});
      end
    end
    @(posedge clk);
    #1;
    chk("credit_valid", 64'(o_credit_valid), 64'(m_cv));
    if (m_cv) chk("credit_ch", 64'(o_credit_ch), 64'(m_cc));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    check_comb("post");
  endtask

  task automatic idle();
    i_valid = 0; i_ch = 0; i_data = 0; i_last = 0; i_dest = 0; i_output_vc = 0; i_cts = 0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  task automatic put(input logic [1:0] ch, input logic [63:0] d, input logic l,
                     input logic [1:0] dst, input logic [1:0] ovc);
    i_valid = 1; i_ch = ch; i_data = d; i_last = l; i_dest = dst; i_output_vc = ovc;
  endtask

  typedef struct {
    bit v; bit [1:0] ch; logic [63:0] d; bit l; bit cts;
    bit [3:0] e_has; bit e_cv; bit e_last; logic [63:0] e_data; bit [1:0] e_dst2; bit [1:0] e_ovc2;
  } vec_t;

  vec_t tbl [7];
  bit [3:0] h_early;
  int   credits;

  initial begin
    idle();
    i_sel_ch = 0;
    m_ovf = 0; m_cv = 0; m_cc = 0;
    do_reset();
    chk("reset has_packet", 64'(o_has_packet), 64'd0);
    chk("reset overflow",   64'(o_overflow),   64'd0);
    chk("reset credit",     64'(o_credit_valid), 64'd0);

    // 3-flit packet on channel 2, then three dequeues.
`ifdef EXA_VCBUF_STORE_FWD_EN
    h_early = 4'b0000;
`else
    h_early = 4'b0100;
`endif
    tbl[0] = '{1, 2, 64'hA1, 0, 0, h_early, 0, 0, 64'hA1, 1, 3};
    tbl[1] = '{1, 2, 64'hA2, 0, 0, h_early, 0, 0, 64'hA1, 1, 3};
    tbl[2] = '{1, 2, 64'hA3, 1, 0, 4'b0100, 0, 0, 64'hA1, 1, 3};
    tbl[3] = '{0, 0, 64'h0,  0, 1, 4'b0100, 1, 0, 64'hA2, 1, 3};
    tbl[4] = '{0, 0, 64'h0,  0, 1, 4'b0100, 1, 1, 64'hA3, 1, 3};
    tbl[5] = '{0, 0, 64'h0,  0, 1, 4'b0000, 1, 0, 64'h0,  0, 0};
    tbl[6] = '{0, 0, 64'h0,  0, 0, 4'b0000, 0, 0, 64'h0,  0, 0};
    i_sel_ch = 2;
    for (int r = 0; r < 7; r++) begin
      idle();
      if (tbl[r].v) put(tbl[r].ch, tbl[r].d, tbl[r].l, 2'd1, 2'd3);
      i_cts = tbl[r].cts;
      cycle();
      chk($sformatf("tbl%0d has_packet", r), 64'(o_has_packet), 64'(tbl[r].e_has));
      chk($sformatf("tbl%0d credit_valid", r), 64'(o_credit_valid), 64'(tbl[r].e_cv));
      if (tbl[r].e_cv) chk($sformatf("tbl%0d credit_ch", r), 64'(o_credit_ch), 64'd2);
      chk($sformatf("tbl%0d last", r), 64'(o_last), 64'(tbl[r].e_last));
      chk($sformatf("tbl%0d data", r), o_data, tbl[r].e_data);
      chk($sformatf("tbl%0d dest2", r), 64'(o_dest[2]), 64'(tbl[r].e_dst2));
      chk($sformatf("tbl%0d ovc2", r), 64'(o_output_vc[2]), 64'(tbl[r].e_ovc2));
    end

    // Overflow on channel 0: 9th write dropped, flag sticky, 8 flits drain.
    do_reset();
    i_sel_ch = 0;
    for (int k = 0; k < 9; k++) begin
      idle(); put(0, 64'(100 + k), k == 7, 0, 1); cycle();
    end
    chk("ovf0 set", 64'(o_overflow), 64'd1);
    idle(); cycle(); cycle();
    chk("ovf0 sticky", 64'(o_overflow), 64'd1);
    credits = 0;
    for (int k = 0; k < 10; k++) begin
      idle(); i_cts = 1; cycle();
      if (o_credit_valid) credits++;
    end
    chk("ovf0 drained flits", 64'(credits), 64'd8);

    // Full channel 1 with simultaneous write and dequeue.
    do_reset();
    i_sel_ch = 1;
    for (int k = 0; k < 8; k++) begin
      idle(); put(1, 64'(200 + k), 1, 2, 0); cycle();
    end
    chk("full1 no ovf yet", 64'(o_overflow), 64'd0);
    idle(); put(1, 64'hDEAD, 1, 3, 3); i_cts = 1; cycle();
    chk("full1 credit", 64'(o_credit_valid), 64'd1);
    chk("full1 ovf", 64'(o_overflow), 64'd1);
    credits = 0;
    for (int k = 0; k < 10; k++) begin
      idle(); i_cts = 1; cycle();
      if (o_credit_valid) credits++;
    end
    chk("full1 remaining", 64'(credits), 64'd7);

    // Dequeue strobe to empty channel 3.
    do_reset();
    i_sel_ch = 3;
    idle(); i_cts = 1; cycle();
    chk("empty3 no credit", 64'(o_credit_valid), 64'd0);
    idle(); put(3, 64'h3333, 1, 2, 1); cycle();
    chk("empty3 head data", o_data, 64'h3333);
    idle(); i_cts = 1; cycle();
    chk("empty3 credit", 64'(o_credit_valid), 64'd1);
    chk("empty3 credit ch", 64'(o_credit_ch), 64'd3);

    // Request timing for partial vs complete packets on channel 0.
    do_reset();
    i_sel_ch = 0;
    idle(); put(0, 64'h1, 0, 1, 1); cycle();
`ifdef EXA_VCBUF_STORE_FWD_EN
    chk("sf first flit", 64'(o_has_packet[0]), 64'd0);
`else
    chk("ct first flit", 64'(o_has_packet[0]), 64'd1);
`endif
    idle(); put(0, 64'h2, 0, 1, 1); cycle();
    idle(); put(0, 64'h3, 1, 1, 1); cycle();
    chk("pkt complete", 64'(o_has_packet[0]), 64'd1);

    // Reset mid-packet on channel 3, then a fresh single-flit packet.
    do_reset();
    i_sel_ch = 3;
    idle(); put(3, 64'h41, 0, 1, 2); cycle();
    idle(); put(3, 64'h42, 0, 1, 2); cycle();
    do_reset();
    chk("midrst has_packet", 64'(o_has_packet), 64'd0);
    chk("midrst dest", 64'(o_dest), 64'd0);
    chk("midrst data", o_data, 64'd0);
    idle(); put(3, 64'h55, 1, 2, 1); cycle();
    chk("midrst fresh has3", 64'(o_has_packet[3]), 64'd1);
    chk("midrst fresh dest3", 64'(o_dest[3]), 64'd2);

    // Randomized traffic in three dequeue-rate regimes.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 600; n++) begin
        idle();
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(0, 1)) put(2'($urandom_range(0, 3)), {$urandom, $urandom},
                                        $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                                        2'($urandom_range(0, 3)));
          i_cts    = $urandom_range(0, 9) < (2 + 3 * ph);
          i_sel_ch = 2'($urandom_range(0, 3));
          cycle();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
